// File: rtl/window3x3_gen.sv
// window3x3_gen: streaming 3x3 neighbourhood generator.
// Pixels arrive in raster order. Two line memories hold the previous two rows,
// a 3x3 column-shift array builds the window, and the taps are registered
// together with the coordinate of the window's centre pixel.
module window3x3_gen #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_valid,
    input  logic [9:0]    x_pixel,
    input  logic [9:0]    y_pixel,
    input  logic [DW-1:0] pix_in,
    output logic          win_valid,
    output logic [9:0]    win_x,
    output logic [9:0]    win_y,
    output logic [DW-1:0] p00,
    output logic [DW-1:0] p01,
    output logic [DW-1:0] p02,
    output logic [DW-1:0] p10,
    output logic [DW-1:0] p11,
    output logic [DW-1:0] p12,
    output logic [DW-1:0] p20,
    output logic [DW-1:0] p21,
    output logic [DW-1:0] p22
);

    localparam int         AW     = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam logic [9:0] X_LAST = 10'(H_ACT - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACT - 1);

    // Line memories: LB0 = row y-1, LB1 = row y-2 (contents never reset)
    logic [DW-1:0] lb0_mem [H_ACT];
    logic [DW-1:0] lb1_mem [H_ACT];

    logic          accept;
    logic          win_ok;
    logic [1:0]    lines_q, lines_d;

    // Input stage (acceptance edge)
    logic          in_valid_q, in_ok_q;
    logic [9:0]    in_x_q, in_y_q;
    logic [DW-1:0] in_pix_q;

    // RAM read stage
    logic [DW-1:0] lb0_rd_q, lb1_rd_q;
    logic          s1_valid_q, s1_ok_q;
    logic [9:0]    s1_x_q, s1_y_q;
    logic [DW-1:0] s1_pix_q;

    // Column array, each column packed [row], row 0 = oldest line
    logic [2:0][DW-1:0] col0_q, col1_q, col2_q;
    logic [2:0][DW-1:0] newcol;
    // Output taps indexed [column][row]
    logic [2:0][2:0][DW-1:0] tap_q;

    assign accept = pix_valid && (x_pixel <= X_LAST) && (y_pixel <= Y_LAST);
    assign win_ok = accept && (lines_q == 2'd2) && (x_pixel >= 10'd2);
    assign newcol = {s1_pix_q, lb0_rd_q, lb1_rd_q};

    // Saturating count of completed rows since frame start or reset
    always_comb begin
        lines_d = lines_q;
        if (accept) begin
            if (x_pixel == '0 && y_pixel == '0) lines_d = '0;
            if (x_pixel == X_LAST && lines_d != 2'd2) lines_d = lines_d + 2'd1;
        end
    end

    // Register accepted pixel, its coordinate and window eligibility
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_valid_q <= 1'b0;
            in_ok_q    <= 1'b0;
            in_x_q     <= '0;
            in_y_q     <= '0;
            in_pix_q   <= '0;
            lines_q    <= '0;
        end else begin
            in_valid_q <= accept;
            lines_q    <= lines_d;
            if (accept) begin
                in_ok_q  <= win_ok;
                in_x_q   <= x_pixel;
                in_y_q   <= y_pixel;
                in_pix_q <= pix_in;
            end
        end
    end

    // Line memories: read-before-write; LB1 is written one edge later from the registered LB0 read
    always_ff @(posedge clk) begin
        if (in_valid_q) begin
            lb0_rd_q                 <= lb0_mem[in_x_q[AW-1:0]];
            lb1_rd_q                 <= lb1_mem[in_x_q[AW-1:0]];
            lb0_mem[in_x_q[AW-1:0]]  <= in_pix_q;
        end
        if (s1_valid_q) begin
            lb1_mem[s1_x_q[AW-1:0]]  <= lb0_rd_q;
        end
    end

    // Carry pixel and coordinate alongside the RAM read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_ok_q    <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_pix_q   <= '0;
        end else begin
            s1_valid_q <= in_valid_q;
            if (in_valid_q) begin
                s1_ok_q  <= in_ok_q;
                s1_x_q   <= in_x_q;
                s1_y_q   <= in_y_q;
                s1_pix_q <= in_pix_q;
            end
        end
    end

    // Shift columns and register the window; taps hold while no window is emitted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col0_q    <= '0;
            col1_q    <= '0;
            col2_q    <= '0;
            tap_q     <= '0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
        end else begin
            win_valid <= s1_valid_q && s1_ok_q;
            if (s1_valid_q) begin
                col0_q <= col1_q;
                col1_q <= col2_q;
                col2_q <= newcol;
                if (s1_ok_q) begin
                    tap_q <= {newcol, col2_q, col1_q};
                    win_x <= s1_x_q - 10'd1;
                    win_y <= s1_y_q - 10'd1;
                end
            end
        end
    end

    assign p00 = tap_q[0][0];
    assign p01 = tap_q[1][0];
    assign p02 = tap_q[2][0];
    assign p10 = tap_q[0][1];
    assign p11 = tap_q[1][1];
    assign p12 = tap_q[2][1];
    assign p20 = tap_q[0][2];
    assign p21 = tap_q[1][2];
    assign p22 = tap_q[2][2];

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen at H_ACT=8, V_ACT=6; pixel value = {y[3:0], x[3:0]}.
module tb_window3x3_gen;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid;
    logic [9:0]    x_pixel, y_pixel;
    logic [DW-1:0] pix_in;
    logic          win_valid;
    logic [9:0]    win_x, win_y;
    logic [DW-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;

    window3x3_gen #(.H_ACT(H), .V_ACT(V), .DW(DW)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid),
        .x_pixel(x_pixel), .y_pixel(y_pixel), .pix_in(pix_in),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
        .p00(p00), .p01(p01), .p02(p02),
        .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   due;
        int            wx;
        int            wy;
        logic [DW-1:0] t [9];
    } win_t;

    typedef struct {
        string         name;
        int            mask;
        int            cx;
        int            cy;
        logic [DW-1:0] t [9];
    } vec_t;

    win_t exp_q[$];
    win_t log_q[$];
    win_t last;
    vec_t tbl [3];

    int nchk   = 0;
    int nfail  = 0;
    int wcount = 0;
    int filled = 0;

    function automatic logic [DW-1:0] pixv(input int x, input int y);
        logic [3:0] xx, yy;
        xx = 4'(x);
        yy = 4'(y);
        return {4'b0000, yy, xx};
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        nchk++;
        if (act != expv) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic clear_last();
        last.due = 0;
        last.wx  = 0;
        last.wy  = 0;
        for (int k = 0; k < 9; k++) last.t[k] = '0;
    endtask

    // Monitor: every window must match the oldest expected one at exactly its due cycle
    always @(posedge clk) begin
        win_t          w;
        win_t          e;
        logic [DW-1:0] cur [9];
        #1;
        cur = '{p00, p01, p02, p10, p11, p12, p20, p21, p22};
        if (win_valid) begin
            wcount++;
            w.due = cyc;
            w.wx  = int'(win_x);
            w.wy  = int'(win_y);
            w.t   = cur;
            log_q.push_back(w);
            if (exp_q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL spurious_window: got centre (%0d,%0d) expected no window", win_x, win_y);
            end else begin
                e = exp_q.pop_front();
                chk("latency_cycle", int'(cyc), int'(e.due));
                chk("win_x", int'(win_x), e.wx);
                chk("win_y", int'(win_y), e.wy);
                for (int k = 0; k < 9; k++) chk($sformatf("tap%0d", k), int'(cur[k]), int'(e.t[k]));
            end
            last = w;
        end else begin
            if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                nchk++;
                nfail++;
                $display("FAIL missing_window: got none expected centre (%0d,%0d)", exp_q[0].wx, exp_q[0].wy);
                void'(exp_q.pop_front());
            end
            chk("hold_win_x", int'(win_x), last.wx);
            chk("hold_win_y", int'(win_y), last.wy);
            chk("hold_p11", int'(p11), int'(last.t[4]));
        end
    end

    // Present one strobe for one clock; in-range pixels update the expected-window model
    task automatic px(input int x, input int y);
        win_t e;
        pix_valid = 1'b1;
        x_pixel   = 10'(x);
        y_pixel   = 10'(y);
        pix_in    = pixv(x, y);
        if (x < H && y < V) begin
            if (x == 0 && y == 0) filled = 0;
            if (filled == 2 && x >= 2) begin
                e.due = cyc + 3;
                e.wx  = x - 1;
                e.wy  = y - 1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.t[r*3 + c] = pixv(x - 2 + c, y - 2 + r);
                exp_q.push_back(e);
            end
            if (x == H - 1 && filled < 2) filled++;
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic frame(input bit gap, input bit inject);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                px(x, y);
                if (gap) @(negedge clk);
                if (inject && x == 3) begin
                    px(8, y);
                    px(x, 6);
                end
            end
        end
    endtask

    task automatic drain();
        repeat (5) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic apply_table(input int s);
        int found;
        for (int i = 0; i < 3; i++) begin
            if (tbl[i].mask[s]) begin
                found = 0;
                foreach (log_q[j]) begin
                    if (log_q[j].wx == tbl[i].cx && log_q[j].wy == tbl[i].cy) begin
                        found++;
                        for (int k = 0; k < 9; k++)
                            chk($sformatf("%s_tap%0d", tbl[i].name, k), int'(log_q[j].t[k]), int'(tbl[i].t[k]));
                    end
                end
                chk({tbl[i].name, "_found"}, int'(found > 0), 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // mask bits: 0 = clean back-to-back frames, 1 = gapped, 2 = injected strobes, 3 = mid-frame reset
        tbl[0] = '{name: "c11", mask: 7, cx: 1, cy: 1,
                   t: '{12'h000, 12'h001, 12'h002, 12'h010, 12'h011, 12'h012, 12'h020, 12'h021, 12'h022}};
        tbl[1] = '{name: "c64", mask: 15, cx: 6, cy: 4,
                   t: '{12'h035, 12'h036, 12'h037, 12'h045, 12'h046, 12'h047, 12'h055, 12'h056, 12'h057}};
        tbl[2] = '{name: "c14_after_reset", mask: 8, cx: 1, cy: 4,
                   t: '{12'h030, 12'h031, 12'h032, 12'h040, 12'h041, 12'h042, 12'h050, 12'h051, 12'h052}};

        clear_last();
        reset     = 1'b1;
        pix_valid = 1'b0;
        x_pixel   = '0;
        y_pixel   = '0;
        pix_in    = '0;
        repeat (2) @(negedge clk);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_win_x", int'(win_x), 0);
        chk("rst_win_y", int'(win_y), 0);
        chk("rst_p00", int'(p00), 0);
        chk("rst_p11", int'(p11), 0);
        chk("rst_p22", int'(p22), 0);
        reset = 1'b0;
        @(negedge clk);

        // Two back-to-back frames, contiguous strobes
        log_q.delete();
        wcount = 0;
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        drain();
        chk("two_frames_window_count", wcount, 48);
        apply_table(0);

        // Alternating strobes
        log_q.delete();
        wcount = 0;
        frame(1'b1, 1'b0);
        drain();
        chk("gapped_window_count", wcount, 24);
        apply_table(1);

        // Out-of-range strobes injected mid-row
        log_q.delete();
        wcount = 0;
        frame(1'b0, 1'b1);
        drain();
        chk("injected_window_count", wcount, 24);
        apply_table(2);

        // Reset during row 3, then resume the frame at (0,3)
        log_q.delete();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < H; x++) px(x, y);
        for (int x = 0; x < 5; x++) px(x, 3);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_win_valid", int'(win_valid), 1);
        reset = 1'b1;
        #1;
        chk("reset_drop_win_valid", int'(win_valid), 0);
        chk("reset_win_x", int'(win_x), 0);
        chk("reset_p11", int'(p11), 0);
        filled = 0;
        exp_q.delete();
        clear_last();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wcount = 0;
        log_q.delete();
        for (int y = 3; y < V; y++)
            for (int x = 0; x < H; x++) px(x, y);
        drain();
        chk("post_reset_window_count", wcount, 6);
        apply_table(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
